// File: rtl/ioctl_upload_server_if.sv
// Upload-direction ioctl bus from hps_io plus the read port into the core-owned byte RAM.
// The slave modport is the server's view; the master modport is the hps_io/core side.
interface ioctl_upload_server_if #(
  parameter int unsigned AW = 12
) ();
  logic          ioctl_upload;
  logic [7:0]    ioctl_index;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic          ram_req;
  logic          ram_gnt;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_q;

  modport slave (
    input  ioctl_upload,
    input  ioctl_index,
    input  ioctl_rd,
    input  ioctl_addr,
    output ioctl_din,
    output ioctl_wait,
    output ram_req,
    output ram_addr,
    input  ram_gnt,
    input  ram_q
  );

  modport master (
    output ioctl_upload,
    output ioctl_index,
    output ioctl_rd,
    output ioctl_addr,
    input  ioctl_din,
    input  ioctl_wait,
    input  ram_req,
    input  ram_addr,
    output ram_gnt,
    output ram_q
  );
endinterface

// File: rtl/ioctl_upload_server.sv
// Serves hps_io upload read requests from a core byte RAM, holding ioctl_wait until the byte
// is valid. Out-of-range addresses are answered with FILL without touching the RAM.
module ioctl_upload_server #(
  parameter logic [7:0]  INDEX  = 8'd4,
  parameter int unsigned AW     = 12,
  parameter int unsigned SIZE   = 4096,
  parameter int unsigned RD_LAT = 1,
  parameter logic [7:0]  FILL   = 8'hFF
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  ioctl_upload_server_if.slave  bus,
  output logic                  pause_req,
  output logic                  upload_done,
  output logic                  proto_err
);

  localparam logic [24:0] ADDR_LIMIT = 25'(SIZE);
  localparam logic [2:0]  CNT_INIT   = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StFill} state_e;

  state_e     state;
  logic [2:0] cnt;
  logic       sel;

  assign sel = bus.ioctl_upload && (bus.ioctl_index == INDEX);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state          <= StIdle;
      cnt            <= 3'd0;
      pause_req      <= 1'b0;
      upload_done    <= 1'b0;
      proto_err      <= 1'b0;
      bus.ioctl_din  <= 8'h00;
      bus.ioctl_wait <= 1'b0;
      bus.ram_req    <= 1'b0;
      bus.ram_addr   <= '0;
    end else begin
      pause_req   <= sel;
      upload_done <= pause_req && !sel;

      // A strobe while busy is dropped; the in-flight request still finishes.
      if (bus.ioctl_rd && (state != StIdle)) begin
        proto_err <= 1'b1;
      end

      if (!sel && (state != StIdle)) begin
        // Upload went away mid-request: abandon it, keep the last returned byte.
        state          <= StIdle;
        bus.ram_req    <= 1'b0;
        bus.ioctl_wait <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            if (bus.ioctl_rd && sel) begin
              bus.ioctl_wait <= 1'b1;
              if (bus.ioctl_addr >= ADDR_LIMIT) begin
                state <= StFill;
              end else begin
                state        <= StReq;
                bus.ram_req  <= 1'b1;
                bus.ram_addr <= bus.ioctl_addr[AW-1:0];
              end
            end
          end
          StReq: begin
            if (bus.ram_gnt) begin
              bus.ram_req <= 1'b0;
              cnt         <= CNT_INIT;
              state       <= StWait;
            end
          end
          StWait: begin
            if (cnt == 3'd0) begin
              bus.ioctl_din  <= bus.ram_q;
              bus.ioctl_wait <= 1'b0;
              state          <= StIdle;
            end else begin
              cnt <= cnt - 3'd1;
            end
          end
          StFill: begin
            bus.ioctl_din  <= FILL;
            bus.ioctl_wait <= 1'b0;
            state          <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Scoreboard bench for ioctl_upload_server: a RAM model with programmable grant delay answers
// the read port; each accepted request pushes its expected byte and latency.
module tb_ioctl_upload_server;
  localparam int unsigned AW     = 12;
  localparam int unsigned SIZE   = 4096;
  localparam int unsigned RD_LAT = 1;
  localparam logic [7:0]  INDEX  = 8'd4;
  localparam logic [7:0]  FILL   = 8'hFF;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic pause_req, upload_done, proto_err;

  ioctl_upload_server_if #(.AW(AW)) bus ();

  ioctl_upload_server #(
    .INDEX (INDEX),
    .AW    (AW),
    .SIZE  (SIZE),
    .RD_LAT(RD_LAT),
    .FILL  (FILL)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .bus        (bus),
    .pause_req  (pause_req),
    .upload_done(upload_done),
    .proto_err  (proto_err)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
    end
  endtask

  // RAM model: read data appears RD_LAT cycles after the granting edge.
  logic [7:0]    mem  [SIZE];
  logic [7:0]    pipe [RD_LAT];
  int unsigned   gnt_delay = 0;
  int unsigned   gnt_wait  = 0;
  logic [AW-1:0] exp_raddr = '0;

  assign bus.ram_gnt = bus.ram_req && (gnt_wait >= gnt_delay);
  assign bus.ram_q   = pipe[RD_LAT-1];

  always @(posedge clk_sys) begin
    gnt_wait <= (bus.ram_req && !bus.ram_gnt) ? gnt_wait + 1 : 0;
    if (bus.ram_req && bus.ram_gnt) pipe[0] <= mem[bus.ram_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    string      tag;
    logic [7:0] din;
    int         lat;
    bit         chk_lat;
    int         start;
  } exp_t;

  exp_t sb[$];

  int   done_cnt = 0;
  int   req_cyc  = 0;
  int   wait_cyc = 0;
  logic wait_q   = 1'b0;

  always @(negedge clk_sys) begin
    exp_t e;
    if (upload_done) done_cnt <= done_cnt + 1;
    if (bus.ioctl_wait) wait_cyc <= wait_cyc + 1;
    if (bus.ram_req) begin
      req_cyc <= req_cyc + 1;
      check_eq("ram_addr_stable", 32'(bus.ram_addr), 32'(exp_raddr));
    end
    if (wait_q && !bus.ioctl_wait) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check_eq({e.tag, "_din"}, 32'(bus.ioctl_din), 32'(e.din));
        if (e.chk_lat) check_eq({e.tag, "_lat"}, cyc - e.start, e.lat);
      end
    end
    wait_q <= bus.ioctl_wait;
  end

  logic [7:0] last_din = 8'h00;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic rd_pulse(input logic [24:0] a);
    bus.ioctl_addr = a;
    bus.ioctl_rd   = 1'b1;
    tick();
    bus.ioctl_rd   = 1'b0;
  endtask

  task automatic push_item(input string tag, input logic [7:0] din, input int lat,
                           input bit chk_lat);
    exp_t e;
    e.tag     = tag;
    e.din     = din;
    e.lat     = lat;
    e.chk_lat = chk_lat;
    e.start   = cyc;
    last_din  = din;
    sb.push_back(e);
  endtask

  task automatic push_read(input string tag, input logic [24:0] a, input int delay);
    gnt_delay = delay;
    if (a >= 25'(SIZE)) begin
      push_item(tag, FILL, 2, 1'b1);
    end else begin
      exp_raddr = a[AW-1:0];
      push_item(tag, mem[a[AW-1:0]], 2 + delay + RD_LAT, 1'b1);
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_eq({tag, "_drained"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic serve(input string tag, input logic [24:0] a, input int delay);
    push_read(tag, a, delay);
    rd_pulse(a);
    wait_drain(tag, 40 + delay);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r0, w0, d0;
    for (int i = 0; i < SIZE; i++) mem[i] = 8'(i * 7 + 3);
    mem[12'h010] = 8'hA5;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_index  = 8'd0;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = '0;

    repeat (3) @(posedge clk_sys);
    #1;
    check_eq("reset_din", 32'(bus.ioctl_din), 32'h00);
    check_eq("reset_wait", 32'(bus.ioctl_wait), 0);
    check_eq("reset_ram_req", 32'(bus.ram_req), 0);
    check_eq("reset_pause", 32'(pause_req), 0);
    check_eq("reset_done", 32'(upload_done), 0);
    check_eq("reset_proto", 32'(proto_err), 0);
    reset_n = 1'b1;
    tick();

    // T1: immediate grant
    bus.ioctl_index  = INDEX;
    bus.ioctl_upload = 1'b1;
    tick();
    tick();
    check_eq("t1_pause", 32'(pause_req), 1);
    serve("t1", 25'h010, 0);

    // T2: grant withheld 5 cycles; request held for those plus the grant cycle
    r0 = req_cyc;
    serve("t2", 25'h123, 5);
    check_eq("t2_req_cycles", req_cyc - r0, 6);

    // Address boundaries
    serve("last", 25'h0FFF, 0);
    r0 = req_cyc;
    serve("t3", 25'h1000, 0);
    check_eq("t3_no_req", req_cyc - r0, 0);
    r0 = req_cyc;
    serve("hi", 25'h1000010, 0);
    check_eq("hi_no_req", req_cyc - r0, 0);

    // T4: other index is ignored
    d0 = done_cnt;
    bus.ioctl_index = 8'd0;
    tick();
    tick();
    check_eq("t4_done_pulse", done_cnt - d0, 1);
    r0 = req_cyc;
    w0 = wait_cyc;
    repeat (3) begin
      rd_pulse(25'h010);
      tick();
    end
    check_eq("t4_no_req", req_cyc - r0, 0);
    check_eq("t4_no_wait", wait_cyc - w0, 0);
    check_eq("t4_pause", 32'(pause_req), 0);
    check_eq("t4_din_kept", 32'(bus.ioctl_din), 32'(last_din));
    check_eq("t4_proto", 32'(proto_err), 0);

    // T5: second strobe lands while the first is in WAIT
    bus.ioctl_index = INDEX;
    tick();
    tick();
    r0 = req_cyc;
    push_read("t5", 25'h020, 0);
    rd_pulse(25'h020);
    tick();
    rd_pulse(25'h030);
    wait_drain("t5", 20);
    repeat (4) tick();
    check_eq("t5_proto", 32'(proto_err), 1);
    check_eq("t5_single_req", req_cyc - r0, 1);
    check_eq("t5_wait_idle", 32'(bus.ioctl_wait), 0);

    // T6: upload dropped while waiting for grant
    gnt_delay = 100;
    exp_raddr = 12'h040;
    d0 = done_cnt;
    push_item("t6", last_din, 2, 1'b1);
    rd_pulse(25'h040);
    check_eq("t6_req_up", 32'(bus.ram_req), 1);
    bus.ioctl_upload = 1'b0;
    tick();
    check_eq("t6_req_drop", 32'(bus.ram_req), 0);
    check_eq("t6_wait_drop", 32'(bus.ioctl_wait), 0);
    wait_drain("t6", 10);
    repeat (4) tick();
    check_eq("t6_done_once", done_cnt - d0, 1);
    check_eq("t6_din_kept", 32'(bus.ioctl_din), 32'(last_din));

    // Async reset in the middle of a request
    bus.ioctl_upload = 1'b1;
    tick();
    tick();
    exp_raddr = 12'h050;
    push_item("rst", 8'h00, 0, 1'b0);
    rd_pulse(25'h050);
    tick();
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_req", 32'(bus.ram_req), 0);
    check_eq("rst_wait", 32'(bus.ioctl_wait), 0);
    check_eq("rst_proto", 32'(proto_err), 0);
    @(posedge clk_sys);
    #1 reset_n = 1'b1;
    wait_drain("rst", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
